// File: rtl/mem_stage.sv
// mem_stage: MEM stage of core_lapido. Runs data-memory loads/stores over a
// req/ready handshake, stalls the front of the pipe while an access is
// outstanding, resolves PC-relative branches and drives the MEM/WB register.

`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef GRP_ADDR_WIDTH
`define GRP_ADDR_WIDTH 5
`endif
`ifndef WB_RES_MEM
`define WB_RES_MEM 2'd1
`endif

module mem_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       mem_write_enable,
  input  logic                       sel_beq_bne,
  input  logic                       sel_jt_jf,
  input  logic                       is_branch,
  input  logic                       sel_jflag_branch,
  input  logic [2:0]                 cond_sel,
  input  logic [1:0]                 wb_res_mux,
  input  logic                       reg_write_enable,
  input  logic [`GRP_ADDR_WIDTH-1:0] reg_dest,
  input  logic [`GPR_WIDTH-1:0]      alu_res,
  input  logic [`GPR_WIDTH-1:0]      mem_addr,
  input  logic [`GPR_WIDTH-1:0]      mem_data,
  input  logic [`GPR_WIDTH-1:0]      imm,
  input  logic [`PC_WIDTH-1:0]       next_pc,
  input  logic [`PC_WIDTH-1:0]       branch_addr,
  input  logic [5:0]                 flags,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [`GPR_WIDTH-1:0]      dmem_addr,
  output logic [`GPR_WIDTH-1:0]      dmem_wdata,
  input  logic [`GPR_WIDTH-1:0]      dmem_rdata,
  input  logic                       dmem_ready,
  output logic                       mem_stall,
  output logic                       pc_src,
  output logic [`PC_WIDTH-1:0]       branch_target,
  output logic                       flush,
  output logic                       out_valid,
  output logic [1:0]                 out_wb_res_mux,
  output logic                       out_reg_write_enable,
  output logic [`GRP_ADDR_WIDTH-1:0] out_reg_dest,
  output logic [`GPR_WIDTH-1:0]      out_alu_res,
  output logic [`GPR_WIDTH-1:0]      out_mem_rdata,
  output logic [`GPR_WIDTH-1:0]      out_imm,
  output logic [`PC_WIDTH-1:0]       out_next_pc
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic is_load, is_store, mem_op, take_branch;

  // WB fields captured when an access starts, released when it completes
  logic                       lat_load_p0;
  logic [1:0]                 lat_wb_res_mux_p0;
  logic                       lat_reg_write_enable_p0;
  logic [`GRP_ADDR_WIDTH-1:0] lat_reg_dest_p0;
  logic [`GPR_WIDTH-1:0]      lat_alu_res_p0;
  logic [`GPR_WIDTH-1:0]      lat_imm_p0;
  logic [`PC_WIDTH-1:0]       lat_next_pc_p0;

  // beq/bne test the zero flag; jt/jf test flags[cond_sel], where the
  // two indices past the 6-bit flag register read as 0.
  function automatic logic branch_taken(input logic [5:0] flg,
                                        input logic [2:0] csel,
                                        input logic       jflag,
                                        input logic       beq_bne,
                                        input logic       jt_jf);
    logic [7:0] ext;
    ext = {2'b00, flg};
    if (jflag)
      return ext[csel] ^ jt_jf;
    else
      return flg[0] ^ beq_bne;
  endfunction

  // A branch never touches memory, whatever its memory control bits say
  assign is_load  = in_valid & reg_write_enable & (wb_res_mux == `WB_RES_MEM) & ~is_branch;
  assign is_store = in_valid & mem_write_enable & ~is_branch;
  assign mem_op   = is_load | is_store;

  assign take_branch = (state_q == IDLE) & in_valid & is_branch &
                       branch_taken(flags, cond_sel, sel_jflag_branch, sel_beq_bne, sel_jt_jf);

  // Handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and the combinational stall seen by upstream
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        mem_stall = ~dmem_ready;
        if (dmem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request, branch redirect and MEM/WB register updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req                <= 1'b0;
      dmem_we                 <= 1'b0;
      dmem_addr               <= '0;
      dmem_wdata              <= '0;
      pc_src                  <= 1'b0;
      branch_target           <= '0;
      flush                   <= 1'b0;
      out_valid               <= 1'b0;
      out_wb_res_mux          <= '0;
      out_reg_write_enable    <= 1'b0;
      out_reg_dest            <= '0;
      out_alu_res             <= '0;
      out_mem_rdata           <= '0;
      out_imm                 <= '0;
      out_next_pc             <= '0;
      lat_load_p0             <= 1'b0;
      lat_wb_res_mux_p0       <= '0;
      lat_reg_write_enable_p0 <= 1'b0;
      lat_reg_dest_p0         <= '0;
      lat_alu_res_p0          <= '0;
      lat_imm_p0              <= '0;
      lat_next_pc_p0          <= '0;
    end else begin
      // ---- branch redirect: one-cycle pulse after the branch is in MEM ----
      pc_src        <= take_branch;
      flush         <= take_branch;
      branch_target <= take_branch ? branch_addr : '0;

      case (state_q)
        IDLE: begin
          if (mem_op) begin
            // ---- access start: drive request, park the WB fields ----
            dmem_req                <= 1'b1;
            dmem_we                 <= is_store;
            dmem_addr               <= mem_addr;
            dmem_wdata              <= mem_data;
            lat_load_p0             <= is_load;
            lat_wb_res_mux_p0       <= wb_res_mux;
            lat_reg_write_enable_p0 <= reg_write_enable;
            lat_reg_dest_p0         <= reg_dest;
            lat_alu_res_p0          <= alu_res;
            lat_imm_p0              <= imm;
            lat_next_pc_p0          <= next_pc;
            out_valid               <= 1'b0;
            out_reg_write_enable    <= 1'b0;
          end else begin
            // ---- pass-through to MEM/WB ----
            out_valid            <= in_valid;
            out_wb_res_mux       <= wb_res_mux;
            out_reg_write_enable <= in_valid & reg_write_enable;
            out_reg_dest         <= reg_dest;
            out_alu_res          <= alu_res;
            out_imm              <= imm;
            out_next_pc          <= next_pc;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            // ---- access complete: release parked entry to MEM/WB ----
            dmem_req             <= 1'b0;
            if (lat_load_p0) out_mem_rdata <= dmem_rdata;
            out_valid            <= 1'b1;
            out_wb_res_mux       <= lat_wb_res_mux_p0;
            out_reg_write_enable <= lat_reg_write_enable_p0;
            out_reg_dest         <= lat_reg_dest_p0;
            out_alu_res          <= lat_alu_res_p0;
            out_imm              <= lat_imm_p0;
            out_next_pc          <= lat_next_pc_p0;
          end else begin
            out_valid            <= 1'b0;
            out_reg_write_enable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
